// File: rtl/int_request_controller.sv
// Interrupt request source for the multicycle control unit: IRQ/NMI edge capture, priority, vectors.
// Optional ack timeout is compiled in when INT_CTRL_TIMEOUT_EN is defined.
module int_request_controller #(
  parameter int unsigned NUM_IRQ    = 8,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'd4,
  parameter logic [31:0] NMI_VEC    = 32'h0000_0080
`ifdef INT_CTRL_TIMEOUT_EN
  ,parameter int unsigned ACK_TIMEOUT = 64
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               nmi_req,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               int_ack,
  input  logic               nmi_ack,
  input  logic               eoi,
  output logic               INT_control,
  output logic               NMI_control,
  output logic [31:0]        int_vector,
  output logic [31:0]        nmi_vector,
  output logic [NUM_IRQ-1:0] pending,
  output logic               in_service,
  output logic               timeout
);

  localparam int unsigned IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NMI  = 2'd1,
    S_INT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] irq_prev_q, pend_q, pend_d, mask_q, mask_d;
  logic [NUM_IRQ-1:0] elig, clr;
  logic               nmi_prev_q, nmi_pend_q, nmi_pend_d, nmi_clr;
  logic               svc_q, svc_d, svc_set;
  logic               to_q, to_d, expired, drop;
  logic [IDW-1:0]     id_q, id_d, sel;
  logic [31:0]        vec_q, vec_d;

  assign elig = pend_q & mask_q;

  // Lowest index wins
  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) sel = IDW'(i);
    end
  end

`ifdef INT_CTRL_TIMEOUT_EN
  localparam int unsigned CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (state_q != S_IDLE) && (cnt_q == CW'(ACK_TIMEOUT - 1));
  assign cnt_d   = (state_q != S_IDLE && state_d != S_IDLE) ? cnt_q + CW'(1) : '0;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      irq_prev_q <= '0;
      pend_q     <= '0;
      mask_q     <= '1;
      nmi_prev_q <= 1'b0;
      nmi_pend_q <= 1'b0;
      svc_q      <= 1'b0;
      to_q       <= 1'b0;
      id_q       <= '0;
      vec_q      <= '0;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= irq;
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      nmi_prev_q <= nmi_req;
      nmi_pend_q <= nmi_pend_d;
      svc_q      <= svc_d;
      to_q       <= to_d;
      id_q       <= id_d;
      vec_q      <= vec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    vec_d   = vec_q;
    clr     = '0;
    nmi_clr = 1'b0;
    svc_set = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (nmi_pend_q) begin
          state_d = S_NMI;
        end else if (|elig && !svc_q) begin
          state_d = S_INT;
          id_d    = sel;
          vec_d   = VEC_BASE + 32'(sel) * VEC_STRIDE;
        end
      end
      S_NMI: begin
        if (nmi_ack) begin
          nmi_clr = 1'b1;
          state_d = S_IDLE;
        end else if (expired) begin
          drop    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_INT: begin
        if (int_ack) begin
          clr[id_q] = 1'b1;
          svc_set   = 1'b1;
          state_d   = S_IDLE;
        end else if (expired) begin
          drop    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // New edges override a same-cycle clear
  assign pend_d     = (pend_q & ~clr) | (irq & ~irq_prev_q);
  assign nmi_pend_d = (nmi_pend_q & ~nmi_clr) | (nmi_req & ~nmi_prev_q);
  assign svc_d      = svc_set | (svc_q & ~eoi);
  assign mask_d     = mask_we ? mask_wdata : mask_q;
  assign to_d       = to_q | drop;

  always_comb begin
    INT_control = (state_q == S_INT);
    NMI_control = (state_q == S_NMI);
    int_vector  = vec_q;
    nmi_vector  = NMI_VEC;
    pending     = pend_q;
    in_service  = svc_q;
    timeout     = to_q;
  end

endmodule

// File: tb/tb_int_request_controller.sv
// Bench for int_request_controller: directed cases plus random traffic
// against a request-level reference model.
module tb_int_request_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  irq = '0;
  logic        nmi_req = 1'b0;
  logic        mask_we = 1'b0;
  logic [7:0]  mask_wdata = '0;
  logic        int_ack = 1'b0;
  logic        nmi_ack = 1'b0;
  logic        eoi = 1'b0;
  logic        INT_control, NMI_control;
  logic [31:0] int_vector, nmi_vector;
  logic [7:0]  pending;
  logic        in_service, timeout;

  int total = 0;
  int bad = 0;

  int_request_controller dut (
    .clk(clk), .rst(rst), .irq(irq), .nmi_req(nmi_req),
    .mask_we(mask_we), .mask_wdata(mask_wdata),
    .int_ack(int_ack), .nmi_ack(nmi_ack), .eoi(eoi),
    .INT_control(INT_control), .NMI_control(NMI_control),
    .int_vector(int_vector), .nmi_vector(nmi_vector),
    .pending(pending), .in_service(in_service), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference model: what the CPU should currently be asked for
  localparam int NONE = 0, WANT_INT = 1, WANT_NMI = 2;
  int         m_req, m_id, m_age;
  bit  [7:0]  m_pend, m_mask, m_prev;
  bit         m_npend, m_nprev, m_svc, m_to;
  bit  [31:0] m_vec;

  task automatic model_step();
    bit [7:0] rise, elig, np;
    bit       nn, ns;
    int       nr;
    if (rst) begin
      m_req = NONE; m_id = 0; m_age = 0; m_pend = 0; m_mask = 8'hFF;
      m_prev = 0; m_npend = 0; m_nprev = 0; m_svc = 0; m_to = 0; m_vec = 0;
      return;
    end
    rise = irq & ~m_prev;
    np = m_pend; nn = m_npend; nr = m_req;
    ns = m_svc && !eoi;
    if (m_req == NONE) begin
      m_age = 0;
      elig = m_pend & m_mask;
      if (m_npend) nr = WANT_NMI;
      else if (elig != 0 && !m_svc) begin
        for (int i = 0; i < 8; i++)
          if (elig[i]) begin m_id = i; break; end
        m_vec = 32'h100 + 32'(4 * m_id);
        nr = WANT_INT;
      end
    end else if (m_req == WANT_NMI && nmi_ack) begin
      nn = 0; nr = NONE;
    end else if (m_req == WANT_INT && int_ack) begin
      np[m_id] = 0; ns = 1; nr = NONE;
    end else begin
`ifdef INT_CTRL_TIMEOUT_EN
      if (m_age == 63) begin nr = NONE; m_to = 1; end
      else m_age++;
`endif
    end
    m_req   = nr;
    m_pend  = np | rise;
    m_npend = nn | (nmi_req & !m_nprev);
    m_svc   = ns;
    if (mask_we) m_mask = mask_wdata;
    m_prev  = irq;
    m_nprev = nmi_req;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("m_int", {31'd0, INT_control}, {31'd0, m_req == WANT_INT});
    chk("m_nmi", {31'd0, NMI_control}, {31'd0, m_req == WANT_NMI});
    chk("m_vec", int_vector, m_vec);
    chk("m_pend", {24'd0, pending}, {24'd0, m_pend});
    chk("m_svc", {31'd0, in_service}, {31'd0, m_svc});
    chk("m_to", {31'd0, timeout}, {31'd0, m_to});
    chk("m_nvec", nmi_vector, 32'h80);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk_model();
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    chk("rst_int", {31'd0, INT_control}, 32'd0);
    chk("rst_vec", int_vector, 32'd0);
    chk("rst_pend", {24'd0, pending}, 32'd0);
    tick();

    // irq[3] edge -> request two edges later
    irq = 8'h08; tick();
    chk("t1_pend", {24'd0, pending}, 32'h08);
    chk("t1_early", {31'd0, INT_control}, 32'd0);
    tick();
    chk("t1_int", {31'd0, INT_control}, 32'd1);
    chk("t1_vec", int_vector, 32'h10C);
    tick(); tick();
    chk("t1_hold", {31'd0, INT_control}, 32'd1);

    // ack, then irq[1] blocked until eoi
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("t2_int", {31'd0, INT_control}, 32'd0);
    chk("t2_pend", {24'd0, pending}, 32'd0);
    chk("t2_svc", {31'd0, in_service}, 32'd1);
    irq = 8'h0A; tick(); tick(); tick();
    chk("t2_block", {31'd0, INT_control}, 32'd0);
    eoi = 1'b1; tick(); eoi = 1'b0;
    chk("t2_eoi", {31'd0, in_service}, 32'd0);
    tick();
    chk("t2_vec", int_vector, 32'h104);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    irq = 8'h00; tick();

    // simultaneous irq[5] and irq[2]
    irq = 8'h24; tick(); tick();
    chk("t3_vec1", int_vector, 32'h108);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    chk("t3_vec2", int_vector, 32'h114);
    chk("t3_int", {31'd0, INT_control}, 32'd1);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    irq = 8'h00;

    // NMI preempts an active handler
    nmi_req = 1'b1; tick(); tick();
    chk("t4_nmi", {31'd0, NMI_control}, 32'd1);
    chk("t4_nvec", nmi_vector, 32'h80);
    nmi_ack = 1'b1; int_ack = 1'b1; tick(); nmi_ack = 1'b0; int_ack = 1'b0;
    chk("t4_drop", {31'd0, NMI_control}, 32'd0);
    chk("t4_svc", {31'd0, in_service}, 32'd1);
    eoi = 1'b1; nmi_req = 1'b0; tick(); eoi = 1'b0;

    // masked irq stays pending
    mask_we = 1'b1; mask_wdata = 8'hF7; tick(); mask_we = 1'b0;
    irq = 8'h08; tick(); tick(); tick();
    chk("t5_pend", {24'd0, pending}, 32'h08);
    chk("t5_mask", {31'd0, INT_control}, 32'd0);
    mask_we = 1'b1; mask_wdata = 8'hFF; tick(); mask_we = 1'b0;
    tick();
    chk("t5_unmask", {31'd0, INT_control}, 32'd1);

    // reset mid-handshake
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_int", {31'd0, INT_control}, 32'd0);
    chk("t6_pend", {24'd0, pending}, 32'd0);
    tick(); tick();
    chk("t6_remask", {31'd0, INT_control}, 32'd1);

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 9) == 0) irq[b] = ~irq[b];
      if ($urandom_range(0, 19) == 0) nmi_req = ~nmi_req;
      mask_we = ($urandom_range(0, 29) == 0);
      mask_wdata = 8'($urandom);
      int_ack = ($urandom_range(0, 3) == 0);
      nmi_ack = ($urandom_range(0, 3) == 0);
      eoi = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    irq = '0; nmi_req = 1'b0; mask_we = 1'b0;
    int_ack = 1'b0; nmi_ack = 1'b0; eoi = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0; tick();

`ifdef INT_CTRL_TIMEOUT_EN
    irq = 8'h08; tick(); tick();
    repeat (63) tick();
    chk("to_hold", {31'd0, INT_control}, 32'd1);
    tick();
    chk("to_drop", {31'd0, INT_control}, 32'd0);
    chk("to_flag", {31'd0, timeout}, 32'd1);
    tick();
    chk("to_again", {31'd0, INT_control}, 32'd1);
`else
    irq = 8'h08; tick(); tick();
    repeat (80) tick();
    chk("hold_long", {31'd0, INT_control}, 32'd1);
    chk("no_to", {31'd0, timeout}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
